// File: rtl/sobolrng_mdim.sv
// Multi-dimensional Sobol sequence generator: DIM samples per step, run-time loadable direction vectors.
// Latency: a sample accepted at an edge is replaced by the next sample in the following cycle (1 sample/cycle).
// Backpressure: iReady=0 holds oRand and the sequence state; optional macro SOBOLRNG_SCRAMBLE_EN adds per-dimension digital shift.
module sobolrng_mdim #(
   parameter int BITWIDTH = 8,
   parameter int DIM      = 2,
   parameter int DIMW     = (DIM > 1) ? $clog2(DIM) : 1,
   parameter int IDXW     = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1
) (
   input  logic                    iClk,
   input  logic                    iRstN,
   input  logic                    iStart,
   input  logic                    iStop,
   input  logic                    iClr,
   input  logic                    iDvWe,
   input  logic [DIMW-1:0]         iDvDim,
   input  logic [IDXW-1:0]         iDvIdx,
   input  logic [BITWIDTH-1:0]     iDvData,
   input  logic                    iSeedWe,
   input  logic [DIM*BITWIDTH-1:0] iSeed,
   input  logic                    iReady,
   output logic                    oValid,
   output logic [DIM*BITWIDTH-1:0] oRand,
   output logic                    oWrap,
   output logic                    oBusy
);

   localparam logic [0:0]          S_IDLE = 1'b0;
   localparam logic [0:0]          S_RUN  = 1'b1;
   localparam logic [BITWIDTH-1:0] LP_ONE = {{(BITWIDTH-1){1'b0}}, 1'b1};

   logic [0:0]          r_state;
   logic [BITWIDTH-1:0] r_cnt;
   logic [BITWIDTH-1:0] r_x  [DIM];
   logic [BITWIDTH-1:0] r_dv [DIM][BITWIDTH];
   logic                r_wrap;

   logic                w_xfer;
   logic                w_last;
   logic [BITWIDTH-1:0] w_onehot;
   logic [BITWIDTH-1:0] w_sel [DIM];

   assign oValid   = (r_state == S_RUN);
   assign oBusy    = (r_state == S_RUN);
   assign oWrap    = r_wrap;
   assign w_xfer   = oValid & iReady;
   // All-ones counter is the last point of the period; the next transfer wraps to sample 0.
   assign w_last   = &r_cnt;
   // One-hot of the lowest zero bit of the counter picks the direction vector for this step.
   assign w_onehot = ~r_cnt & (r_cnt + LP_ONE);

   // Run/idle control; a simultaneous start and stop in RUN resolves to stop.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (iStart) r_state <= S_RUN;
            S_RUN:   if (iStop)  r_state <= S_IDLE;
            default:             r_state <= S_IDLE;
         endcase
      end
   end

   // Direction-vector file: van der Corput on reset, writable only while idle; out-of-range writes match no entry.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         for (int d = 0; d < DIM; d++) begin
            for (int i = 0; i < BITWIDTH; i++) begin
               r_dv[d][i] <= LP_ONE << (BITWIDTH - 1 - i);
            end
         end
      end else if (iDvWe && (r_state == S_IDLE)) begin
         for (int d = 0; d < DIM; d++) begin
            for (int i = 0; i < BITWIDTH; i++) begin
               if ((int'(iDvDim) == d) && (int'(iDvIdx) == i)) begin
                  r_dv[d][i] <= iDvData;
               end
            end
         end
      end
   end

   // Per-dimension vector select as an OR of one-hot-gated entries (no wide mux).
   always_comb begin
      for (int d = 0; d < DIM; d++) begin
         w_sel[d] = '0;
         for (int i = 0; i < BITWIDTH; i++) begin
            w_sel[d] = w_sel[d] | (r_dv[d][i] & {BITWIDTH{w_onehot[i]}});
         end
      end
   end

   // Sequence state: clear beats a coincident transfer; the wrap transfer returns every dimension to zero.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         r_cnt <= '0;
         for (int d = 0; d < DIM; d++) r_x[d] <= '0;
      end else if (iClr) begin
         r_cnt <= '0;
         for (int d = 0; d < DIM; d++) r_x[d] <= '0;
      end else if (w_xfer) begin
         if (w_last) begin
            r_cnt <= '0;
            for (int d = 0; d < DIM; d++) r_x[d] <= '0;
         end else begin
            r_cnt <= r_cnt + LP_ONE;
            for (int d = 0; d < DIM; d++) r_x[d] <= r_x[d] ^ w_sel[d];
         end
      end
   end

   // Wrap flag is high for exactly the cycle that shows the restarted sample 0.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_xfer & w_last & ~iClr;
      end
   end

`ifdef SOBOLRNG_SCRAMBLE_EN
   logic [BITWIDTH-1:0] r_seed [DIM];

   // Seed load is accepted in any state; clear leaves the seeds alone.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         for (int d = 0; d < DIM; d++) r_seed[d] <= '0;
      end else if (iSeedWe) begin
         for (int d = 0; d < DIM; d++) r_seed[d] <= iSeed[d*BITWIDTH +: BITWIDTH];
      end
   end

   // Output is register XOR register: random digital shift of each dimension.
   always_comb begin
      oRand = '0;
      for (int d = 0; d < DIM; d++) begin
         oRand[d*BITWIDTH +: BITWIDTH] = r_x[d] ^ r_seed[d];
      end
   end
`else
   logic w_unused_seed;
   assign w_unused_seed = ^{iSeedWe, iSeed};

   // Output is the raw sample register of each dimension.
   always_comb begin
      oRand = '0;
      for (int d = 0; d < DIM; d++) begin
         oRand[d*BITWIDTH +: BITWIDTH] = r_x[d];
      end
   end
`endif

endmodule

// File: tb/tb_sobolrng_mdim.sv
// Directed bench for sobolrng_mdim at BITWIDTH=4, DIM=2 (DIMW widened to 2 so dimension 2 is addressable).
// Table of per-cycle control inputs and expected outputs, plus hand sequences for loads, reset and seeding.
module tb_sobolrng_mdim;

   logic       iClk = 1'b0;
   logic       iRstN, iStart, iStop, iClr, iDvWe, iSeedWe, iReady;
   logic [1:0] iDvDim, iDvIdx;
   logic [3:0] iDvData;
   logic [7:0] iSeed;
   logic       oValid, oWrap, oBusy;
   logic [7:0] oRand;

   int n_vec = 0;
   int n_err = 0;

   always #5 iClk = ~iClk;

   sobolrng_mdim #(.BITWIDTH(4), .DIM(2), .DIMW(2)) dut (
      .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iStop(iStop), .iClr(iClr),
      .iDvWe(iDvWe), .iDvDim(iDvDim), .iDvIdx(iDvIdx), .iDvData(iDvData),
      .iSeedWe(iSeedWe), .iSeed(iSeed), .iReady(iReady),
      .oValid(oValid), .oRand(oRand), .oWrap(oWrap), .oBusy(oBusy)
   );

   typedef struct {
      logic       start, stop, clr, ready;
      logic       exp_valid, exp_wrap;
      logic [3:0] exp0, exp1;
   } vec_t;

   vec_t tbl[$];

   // van der Corput order for 4 bits with default direction vectors
   logic [3:0] seq [16] = '{4'd0, 4'd8, 4'd12, 4'd4, 4'd6, 4'd14, 4'd10, 4'd2,
                            4'd3, 4'd11, 4'd15, 4'd7, 4'd5, 4'd13, 4'd9, 4'd1};

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic sp, input logic cl, input logic rd,
                      input logic v, input logic w, input logic [3:0] e0, input logic [3:0] e1);
      vec_t t;
      t.start = st; t.stop = sp; t.clr = cl; t.ready = rd;
      t.exp_valid = v; t.exp_wrap = w; t.exp0 = e0; t.exp1 = e1;
      tbl.push_back(t);
   endtask

   initial begin
      logic [3:0] s0;
`ifdef SOBOLRNG_SCRAMBLE_EN
      s0 = 4'h5;
`else
      s0 = 4'h0;
`endif
      iRstN = 1'b0; iStart = 1'b0; iStop = 1'b0; iClr = 1'b0; iDvWe = 1'b0;
      iDvDim = '0; iDvIdx = '0; iDvData = '0; iSeedWe = 1'b0; iSeed = '0; iReady = 1'b0;

      // full period, backpressure, stop/resume, clear over transfer, start+stop together
      add(1, 0, 0, 0, 1, 0, 4'd0, 4'd0);
      for (int j = 1; j <= 16; j++) add(0, 0, 0, 1, 1, (j == 16), seq[j % 16], seq[j % 16]);
      add(0, 0, 0, 1, 1, 0, 4'd8, 4'd8);
      add(0, 0, 0, 0, 1, 0, 4'd8, 4'd8);
      add(0, 0, 0, 0, 1, 0, 4'd8, 4'd8);
      add(0, 0, 0, 1, 1, 0, 4'd12, 4'd12);
      add(0, 0, 0, 1, 1, 0, 4'd4, 4'd4);
      add(0, 0, 0, 1, 1, 0, 4'd6, 4'd6);
      add(0, 1, 0, 1, 0, 0, 4'd14, 4'd14);
      add(0, 0, 0, 1, 0, 0, 4'd14, 4'd14);
      add(0, 0, 0, 1, 0, 0, 4'd14, 4'd14);
      add(1, 0, 0, 1, 1, 0, 4'd14, 4'd14);
      add(0, 0, 0, 1, 1, 0, 4'd10, 4'd10);
      add(0, 0, 1, 1, 1, 0, 4'd0, 4'd0);
      add(0, 0, 0, 1, 1, 0, 4'd8, 4'd8);
      add(1, 1, 0, 0, 0, 0, 4'd8, 4'd8);

      // reset state
      step(); step();
      cmp("rst_valid", 32'(oValid), 32'd0);
      cmp("rst_busy", 32'(oBusy), 32'd0);
      cmp("rst_wrap", 32'(oWrap), 32'd0);
      cmp("rst_rand", 32'(oRand), 32'd0);
      iRstN = 1'b1;
      step();

      for (int i = 0; i < tbl.size(); i++) begin
         iStart = tbl[i].start; iStop = tbl[i].stop; iClr = tbl[i].clr; iReady = tbl[i].ready;
         step();
         cmp($sformatf("tbl%0d_valid", i), 32'(oValid), 32'(tbl[i].exp_valid));
         cmp($sformatf("tbl%0d_busy", i), 32'(oBusy), 32'(tbl[i].exp_valid));
         cmp($sformatf("tbl%0d_wrap", i), 32'(oWrap), 32'(tbl[i].exp_wrap));
         cmp($sformatf("tbl%0d_rand", i), 32'(oRand), 32'({tbl[i].exp1, tbl[i].exp0}));
      end
      iStart = 1'b0; iStop = 1'b0; iClr = 1'b0; iReady = 1'b0;

      // clear in IDLE, then vector loads including an out-of-range dimension
      iClr = 1'b1; step(); iClr = 1'b0;
      cmp("idle_clr", 32'(oRand), 32'd0);
      cmp("idle_clr_wrap", 32'(oWrap), 32'd0);
      iDvWe = 1'b1;
      iDvDim = 2'd1; iDvIdx = 2'd0; iDvData = 4'hF; step();
      iDvDim = 2'd1; iDvIdx = 2'd1; iDvData = 4'h3; step();
      iDvDim = 2'd2; iDvIdx = 2'd0; iDvData = 4'h1; step();
      iDvWe = 1'b0;
      iStart = 1'b1; step(); iStart = 1'b0; iReady = 1'b1;
      cmp("dv_run_valid", 32'(oValid), 32'd1);
      cmp("dv_s0", 32'(oRand), 32'h00);
      step(); cmp("dv_s1", 32'(oRand), 32'hF8);
      step(); cmp("dv_s2", 32'(oRand), 32'hCC);
      step(); cmp("dv_s3", 32'(oRand), 32'h34);
      // write attempted while running must not land
      iDvWe = 1'b1; iDvDim = 2'd0; iDvIdx = 2'd0; iDvData = 4'hF;
      step(); iDvWe = 1'b0;
      cmp("dv_s4", 32'(oRand), 32'h16);
      step(); cmp("dv_s5_run_write_ignored", 32'(oRand), 32'hEE);

      // reset mid-run restores everything, including direction vectors
      iRstN = 1'b0; step();
      cmp("midrst_valid", 32'(oValid), 32'd0);
      cmp("midrst_busy", 32'(oBusy), 32'd0);
      cmp("midrst_rand", 32'(oRand), 32'd0);
      iRstN = 1'b1;
      iStart = 1'b1; step(); iStart = 1'b0;
      cmp("restart_s0", 32'(oRand), 32'h00);
      cmp("restart_valid", 32'(oValid), 32'd1);
      step(); cmp("restart_dv_default", 32'(oRand), 32'h88);
      iStop = 1'b1; step(); iStop = 1'b0;
      iClr = 1'b1; step(); iClr = 1'b0;
      cmp("pre_seed_clr", 32'(oRand), 32'h00);

      // seed dimension 0 only; shift applies only when the scramble build is used
      iSeedWe = 1'b1; iSeed = 8'h05; step(); iSeedWe = 1'b0; iSeed = 8'h00;
      iStart = 1'b1; step(); iStart = 1'b0;
      for (int j = 0; j < 4; j++) begin
         cmp($sformatf("seed_s%0d", j), 32'(oRand), 32'({seq[j], seq[j] ^ s0}));
         step();
      end
      iReady = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sobolrng_mdim.md
Name: sobolrng_mdim

Overview:
Multi-dimensional, parametrised Sobol sequence generator. Successor to the single-channel core: generates its own one-hot step index from an internal counter, holds a per-dimension direction-vector register file loadable at run time, and delivers DIM samples per step over a valid/ready stream. It feeds the unary bitstream comparators, one dimension per operand stream.

Parameters:
BITWIDTH, 8, sample width; sequence period is 2^BITWIDTH.
DIM, 2, number of independent dimensions (channels), 1..16.
DIMW, (DIM>1 ? $clog2(DIM) : 1), width of the dimension select.
IDXW, (BITWIDTH>1 ? $clog2(BITWIDTH) : 1), width of the direction-vector index.

Ports:
iClk  in  1  clock, rising edge.
iRstN  in  1  synchronous active-low reset.
iStart  in  1  IDLE->RUN request.
iStop  in  1  RUN->IDLE request; sequence state is held.
iClr  in  1  restart the sequence at sample 0.
iDvWe  in  1  direction-vector write strobe.
iDvDim  in  DIMW  dimension being written.
iDvIdx  in  IDXW  direction-vector index being written.
iDvData  in  BITWIDTH  direction-vector value.
iSeedWe  in  1  scramble-seed write strobe (used only with macro).
iSeed  in  DIM*BITWIDTH  scramble seeds, dimension d at [d*BITWIDTH +: BITWIDTH].
iReady  in  1  consumer accepts the current sample.
oValid  out  1  sample valid.
oRand  out  DIM*BITWIDTH  samples, dimension d at [d*BITWIDTH +: BITWIDTH].
oWrap  out  1  one-cycle pulse when the sequence wraps.
oBusy  out  1  high in RUN.

Behaviour:
- Reset (iRstN=0 at an iClk edge): state IDLE. Counter cnt=0. All internal sample registers x[d]=0. oValid=0, oWrap=0, oBusy=0. Every dimension's direction vectors set to van der Corput: dv[d][i] = 1 << (BITWIDTH-1-i). Seeds = 0.
- FSM IDLE: oValid=0. iStart=1 -> RUN on the next edge. Writes with iDvWe=1 go to dv[iDvDim][iDvIdx] on that edge. A write with iDvDim>=DIM is dropped.
- FSM RUN: oBusy=1, oValid=1. iDvWe is ignored. iStop=1 -> IDLE on the next edge; cnt and x are kept, so a later iStart resumes the sequence at the same sample. If iStart and iStop are high together in RUN, iStop wins.
- Transfer: oValid & iReady at an edge.
  - Step index k = position of the lowest 0 bit of cnt; one-hot = ~cnt & (cnt+1).
  - Each dimension updates x[d] <= x[d] ^ dv[d][k], where the selected vector is the OR of one-hot-gated vectors; cnt <= cnt+1.
  - The new sample is visible in the cycle after the transfer, so throughput is 1 sample/cycle.
- Wrap: a transfer with cnt = all-ones gives x[d] <= 0 and cnt <= 0, and oWrap = 1 for the following cycle. 2^BITWIDTH distinct points are emitted per period.
- iClr: in any state, x <= 0, cnt <= 0 on that edge. It overrides a coincident transfer. No oWrap. The FSM state is unchanged.
- While iReady=0 in RUN, oRand stays stable.
- oRand is a registered value, or a register XOR register (see Optional Feature); no combinational path from inputs.
- Reset mid-RUN: everything returns to reset values, including any direction vectors loaded earlier.

Optional Feature:
SOBOLRNG_SCRAMBLE_EN.
- Defined: iSeedWe=1 loads iSeed into the per-dimension seed registers. The write is accepted in any state and takes effect on the next cycle. Output is oRand[d] = x[d] ^ seed[d] (random digital shift); iClr does not clear the seeds.
- Undefined: the seed registers are not built, iSeedWe and iSeed are ignored, and oRand[d] = x[d].

Test Plan:
1. BITWIDTH=4, DIM=2, reset defaults, iStart, iReady=1 -> each dimension emits 0,8,12,4,6,14,10,2,3,11,15,7,5,13,9,1. oWrap pulses after sample 1. Sample 0 follows.
2. IDLE: write dv[1][0]=4'hF, dv[1][1]=4'h3, then run -> dim1 emits 0,F,C,3 while dim0 keeps 0,8,12,4. A write in RUN is ignored, and a write with iDvDim=2 is dropped.
3. RUN with iReady toggled 1,0,0,1 -> oRand is held during the low cycles, and samples follow the same order with no skips or repeats.
4. Mid-sequence (sample 6), iStop then iStart three cycles later -> resumes at sample 14. iClr coincident with a transfer -> next oRand = 0, no oWrap.
5. Reset asserted at sample 5 in RUN -> the next edge gives oValid=0, oRand=0, and defaults restored. Restart gives sample 0.
6. Macro on: seed dim0=4'h5, run -> dim0 emits 5,D,9,1,... (sequence XOR 5). Macro off: same stimulus gives the unshifted sequence.
